// File: rtl/icache_pkg.sv
// FSM encoding and parameter-derived widths shared by the refill cache and its storage.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MISS   = 2'd1,
    ST_REFILL = 2'd2,
    ST_FILL   = 2'd3
  } state_t;

  function automatic int off_w(input int w_line);
    return $clog2(w_line / 8);
  endfunction

  function automatic int tag_w(input int w_pc, input int w_index, input int w_line);
    return w_pc - w_index - off_w(w_line);
  endfunction

  function automatic int n_beats(input int w_line, input int w_mem);
    return w_line / w_mem;
  endfunction

  // A single-beat line still needs a one-bit counter to stay a legal vector.
  function automatic int cnt_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped valid/tag/data storage: combinational read, one registered write, flush-all.
// Only valid bits are reset; tag and data contents are meaningless until their valid bit is set.
module icache_array #(
  parameter int W_INDEX = 6,
  parameter int W_TAG   = 22,
  parameter int W_LINE  = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W_INDEX-1:0] i_rd_idx,
  output logic               o_rd_valid,
  output logic [W_TAG-1:0]   o_rd_tag,
  output logic [W_LINE-1:0]  o_rd_line,
  input  logic               i_we,
  input  logic [W_INDEX-1:0] i_wr_idx,
  input  logic [W_TAG-1:0]   i_wr_tag,
  input  logic [W_LINE-1:0]  i_wr_line,
  input  logic               i_flush
);

  localparam int N_ENTRY = 2 ** W_INDEX;

  logic [N_ENTRY-1:0] r_valid;
  logic [W_TAG-1:0]   r_tag  [N_ENTRY];
  logic [W_LINE-1:0]  r_data [N_ENTRY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_dm_refill.sv
// Direct-mapped I-cache: hits return a line one cycle after ifq_ren; misses issue a line refill,
// assemble N_BEATS beats and return the line the cycle after the array write. ifq_ren ignored while busy.
module icache_dm_refill
  import icache_pkg::*;
#(
  parameter int W_PC    = 32,
  parameter int W_LINE  = 128,
  parameter int W_MEM   = 32,
  parameter int W_INDEX = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W_PC-1:0]   ifq_pcin,
  input  logic              ifq_ren,
  input  logic              ifq_abort,
  input  logic              ifq_flush,
  output logic [W_LINE-1:0] ifq_dout,
  output logic              ifq_dout_valid,
  output logic              ifq_busy,
  output logic              mem_req,
  output logic [W_PC-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [W_MEM-1:0]  mem_rdata,
  input  logic              mem_rvalid
);

  localparam int OFF_W = off_w(W_LINE);
  localparam int TAG_W = tag_w(W_PC, W_INDEX, W_LINE);
  localparam int NB    = n_beats(W_LINE, W_MEM);
  localparam int CNT_W = cnt_w(NB);

  state_t              r_state, w_state_nxt;
  logic [W_LINE-1:0]   r_dout, r_line;
  logic                r_dout_valid, r_mem_req, r_abort_pend, r_flush_pend;
  logic [W_PC-1:0]     r_mem_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [TAG_W-1:0]    r_req_tag;
  logic [W_INDEX-1:0]  r_req_idx;

  logic [W_INDEX-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag, w_rd_tag;
  logic [W_LINE-1:0]   w_rd_line;
  logic                w_rd_valid, w_lookup, w_hit, w_miss, w_flush_arr, w_arr_we;
  logic                w_unused_off;

  assign w_idx        = ifq_pcin[OFF_W +: W_INDEX];
  assign w_tag        = ifq_pcin[W_PC-1 -: TAG_W];
  assign w_unused_off = ^ifq_pcin[OFF_W-1:0];

  icache_array #(.W_INDEX(W_INDEX), .W_TAG(TAG_W), .W_LINE(W_LINE)) u_array (
    .clk        (clk),
    .reset      (reset),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_line  (w_rd_line),
    .i_we       (w_arr_we),
    .i_wr_idx   (r_req_idx),
    .i_wr_tag   (r_req_tag),
    .i_wr_line  (r_line),
    .i_flush    (w_flush_arr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_flush_arr = 1'b0;
    w_lookup    = 1'b0;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    w_arr_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A flush (fresh or deferred) invalidates before the lookup, so a same-cycle fetch misses.
        w_flush_arr = ifq_flush | r_flush_pend;
        w_lookup    = ifq_ren & ~ifq_abort;
        w_hit       = w_lookup & ~w_flush_arr & w_rd_valid & (w_rd_tag == w_tag);
        w_miss      = w_lookup & ~w_hit;
        if (w_miss) w_state_nxt = ST_MISS;
      end
      ST_MISS: begin
        if (mem_ack)        w_state_nxt = ST_REFILL;
        else if (ifq_abort) w_state_nxt = ST_IDLE;
      end
      ST_REFILL: begin
        if (mem_rvalid && (r_cnt == CNT_W'(NB - 1))) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        w_arr_we    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_cnt        <= '0;
      r_line       <= '0;
      r_abort_pend <= 1'b0;
      r_flush_pend <= 1'b0;
      r_req_tag    <= '0;
      r_req_idx    <= '0;
    end else begin
      r_dout_valid <= 1'b0;
      if (r_state == ST_IDLE)  r_flush_pend <= 1'b0;
      else if (ifq_flush)      r_flush_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_dout       <= w_rd_line;
            r_dout_valid <= 1'b1;
          end else if (w_miss) begin
            r_req_tag    <= w_tag;
            r_req_idx    <= w_idx;
            r_mem_req    <= 1'b1;
            r_mem_addr   <= {w_tag, w_idx, {OFF_W{1'b0}}};
            r_cnt        <= '0;
            r_abort_pend <= 1'b0;
          end
        end
        ST_MISS: begin
          // Abort on the acceptance cycle behaves like an abort during the refill.
          if (mem_ack) begin
            r_mem_req    <= 1'b0;
            r_abort_pend <= ifq_abort;
          end else if (ifq_abort) begin
            r_mem_req    <= 1'b0;
          end
        end
        ST_REFILL: begin
          if (ifq_abort) r_abort_pend <= 1'b1;
          if (mem_rvalid) begin
            for (int k = 0; k < NB; k++) begin
              if (r_cnt == CNT_W'(k)) r_line[k*W_MEM +: W_MEM] <= mem_rdata;
            end
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FILL: begin
          if (!(r_abort_pend || ifq_abort)) begin
            r_dout       <= r_line;
            r_dout_valid <= 1'b1;
          end
          r_abort_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ifq_dout       = r_dout;
  assign ifq_dout_valid = r_dout_valid;
  assign ifq_busy       = (r_state != ST_IDLE);
  assign mem_req        = r_mem_req;
  assign mem_addr       = r_mem_addr;

endmodule

// File: tb/tb_icache_dm_refill.sv
// Directed bench for icache_dm_refill: cold miss, hit stream, conflict, abort, flush, mid-refill reset.
module tb_icache_dm_refill;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  ifq_pcin;
  logic         ifq_ren, ifq_abort, ifq_flush;
  logic [127:0] ifq_dout;
  logic         ifq_dout_valid, ifq_busy, mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         mem_rvalid;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] LINE1 = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] LINE2 = 128'hAAAA0004_AAAA0003_AAAA0002_AAAA0001;
  localparam logic [127:0] LINE3 = 128'h5555000D_5555000C_5555000B_5555000A;

  icache_dm_refill dut (
    .clk            (clk),
    .reset          (reset),
    .ifq_pcin       (ifq_pcin),
    .ifq_ren        (ifq_ren),
    .ifq_abort      (ifq_abort),
    .ifq_flush      (ifq_flush),
    .ifq_dout       (ifq_dout),
    .ifq_dout_valid (ifq_dout_valid),
    .ifq_busy       (ifq_busy),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_cycle(input logic [31:0] pc);
    ifq_pcin = pc;
    ifq_ren  = 1'b1;
    tick();
    ifq_ren  = 1'b0;
  endtask

  // Entered in MISS; acks at once, streams four beats with one gap, optional abort/flush mid-refill.
  task automatic do_refill(input string tag, input logic [127:0] line, input bit ab, input bit fl);
    logic [127:0] l;
    l = line;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk({tag, "_req_drop"}, mem_req, 1'b0);
    for (int k = 0; k < 4; k++) begin
      mem_rdata  = l[k*32 +: 32];
      mem_rvalid = 1'b1;
      if (k == 1) begin
        ifq_abort = ab;
        ifq_flush = fl;
      end
      tick();
      mem_rvalid = 1'b0;
      ifq_abort  = 1'b0;
      ifq_flush  = 1'b0;
      if (k == 1) tick();
    end
    chk({tag, "_fill_busy"}, ifq_busy, 1'b1);
    tick();
    chk({tag, "_idle"}, ifq_busy, 1'b0);
    chk({tag, "_pulse"}, ifq_dout_valid, !ab);
  endtask

  initial begin
    reset = 1'b1; ifq_pcin = '0; ifq_ren = 1'b0; ifq_abort = 1'b0; ifq_flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    tick(); tick();
    chk("rst_dout", ifq_dout, '0);
    chk("rst_valid", ifq_dout_valid, 1'b0);
    chk("rst_busy", ifq_busy, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, '0);
    reset = 1'b0;
    tick();

    // Cold miss, with a stray beat during MISS that must be ignored
    req_cycle(32'h0000_0040);
    chk("cold_busy", ifq_busy, 1'b1);
    chk("cold_req", mem_req, 1'b1);
    chk("cold_addr", mem_addr, 32'h40);
    mem_rdata = 32'hDEAD_BEEF; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("cold_req_hold", mem_req, 1'b1);
    chk("cold_addr_hold", mem_addr, 32'h40);
    do_refill("cold", LINE1, 1'b0, 1'b0);
    chk("cold_dout", ifq_dout, LINE1);
    tick();
    chk("cold_one_pulse", ifq_dout_valid, 1'b0);
    chk("cold_dout_hold", ifq_dout, LINE1);

    // Hit stream
    ifq_ren = 1'b1;
    ifq_pcin = 32'h40; tick();
    chk("hit0_v", ifq_dout_valid, 1'b1); chk("hit0_d", ifq_dout, LINE1);
    ifq_pcin = 32'h44; tick();
    chk("hit1_v", ifq_dout_valid, 1'b1); chk("hit1_d", ifq_dout, LINE1);
    ifq_pcin = 32'h48; tick();
    chk("hit2_v", ifq_dout_valid, 1'b1); chk("hit2_d", ifq_dout, LINE1);
    chk("hit_no_req", mem_req, 1'b0);
    ifq_ren = 1'b0; tick();
    chk("hit_end", ifq_dout_valid, 1'b0);

    // Conflict on index 4
    req_cycle(32'h0000_0440);
    chk("conf_req", mem_req, 1'b1);
    chk("conf_addr", mem_addr, 32'h440);
    do_refill("conf", LINE2, 1'b0, 1'b0);
    chk("conf_dout", ifq_dout, LINE2);
    req_cycle(32'h0000_0040);
    chk("conf_remiss", mem_req, 1'b1);
    do_refill("conf2", LINE1, 1'b0, 1'b0);
    chk("conf2_dout", ifq_dout, LINE1);

    // Abort in MISS before ack
    req_cycle(32'h0000_0050);
    chk("abm_req", mem_req, 1'b1);
    ifq_abort = 1'b1; tick(); ifq_abort = 1'b0;
    chk("abm_busy", ifq_busy, 1'b0);
    chk("abm_req_drop", mem_req, 1'b0);
    chk("abm_nopulse", ifq_dout_valid, 1'b0);
    tick();
    chk("abm_still_idle", mem_req, 1'b0);

    // Abort mid-refill: line written, no pulse, later fetch hits
    req_cycle(32'h0000_0050);
    do_refill("abr", LINE3, 1'b1, 1'b0);
    chk("abr_dout_hold", ifq_dout, LINE1);
    req_cycle(32'h0000_0050);
    chk("abr_hit_v", ifq_dout_valid, 1'b1);
    chk("abr_hit_d", ifq_dout, LINE3);
    chk("abr_hit_noreq", mem_req, 1'b0);

    // Flush in IDLE, then flush together with ren
    ifq_flush = 1'b1; tick(); ifq_flush = 1'b0;
    req_cycle(32'h0000_0040);
    chk("fli_miss", mem_req, 1'b1);
    do_refill("fli", LINE1, 1'b0, 1'b0);
    ifq_flush = 1'b1;
    req_cycle(32'h0000_0040);
    ifq_flush = 1'b0;
    chk("flr_same_cycle_miss", mem_req, 1'b1);

    // Flush during refill: deferred past the FILL write
    do_refill("flr", LINE1, 1'b0, 1'b1);
    chk("flr_dout", ifq_dout, LINE1);
    req_cycle(32'h0000_0040);
    chk("flr_miss", mem_req, 1'b1);

    // Reset after two refill beats
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rdata = 32'h7700_0000 + k; mem_rvalid = 1'b1; tick();
    end
    mem_rvalid = 1'b0;
    reset = 1'b1; #1;
    chk("mrst_busy", ifq_busy, 1'b0);
    chk("mrst_dout", ifq_dout, '0);
    chk("mrst_valid", ifq_dout_valid, 1'b0);
    chk("mrst_req", mem_req, 1'b0);
    chk("mrst_addr", mem_addr, '0);
    tick();
    reset = 1'b0;
    tick();
    req_cycle(32'h0000_0040);
    chk("mrst_miss", mem_req, 1'b1);
    do_refill("mrst", LINE2, 1'b0, 1'b0);
    chk("mrst_dout2", ifq_dout, LINE2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_dm_refill.md
ICACHE_DM_REFILL -- requirements
Module: icache_dm_refill

Interface
REQ-001 Parameter W_PC, default 32, SHALL set the fetch address width.
REQ-002 Parameter W_LINE, default 128, SHALL set the cache line and ifq_dout width, power of 2.
REQ-003 Parameter W_MEM, default 32, SHALL set the refill beat width; W_LINE/W_MEM (N_BEATS) SHALL be a power of 2 and at least 1.
REQ-004 Parameter W_INDEX, default 6, SHALL set the index width; N_ENTRY = 2**W_INDEX.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 ifq_pcin  in  W_PC  fetch byte address.
REQ-008 ifq_ren  in  1  fetch request.
REQ-009 ifq_abort  in  1  cancel current/pending fetch.
REQ-010 ifq_flush  in  1  invalidate all lines.
REQ-011 ifq_dout  out  W_LINE  fetched line, registered.
REQ-012 ifq_dout_valid  out  1  one-cycle pulse qualifying ifq_dout.
REQ-013 ifq_busy  out  1  high when FSM not IDLE; ifq_ren ignored while high.
REQ-014 mem_req  out  1  line refill request, held until mem_ack.
REQ-015 mem_addr  out  W_PC  line-aligned refill address (offset bits zero).
REQ-016 mem_ack  in  1  request accepted.
REQ-017 mem_rdata  in  W_MEM  refill beat.
REQ-018 mem_rvalid  in  1  beat valid.

Function
REQ-019 Address split SHALL be offset = log2(W_LINE/8) LSBs, index = next W_INDEX bits, tag = remaining MSBs (defaults: [3:0], [9:4], [31:10]).
REQ-020 Storage SHALL be direct-mapped: per entry one valid bit, one tag, one W_LINE data line.
REQ-021 FSM states SHALL be IDLE, MISS, REFILL, FILL.
REQ-022 In IDLE, ifq_ren & ~ifq_abort at cycle N SHALL perform a lookup; on hit, ifq_dout = line and ifq_dout_valid = 1 at N+1 (latency 1); back-to-back hits SHALL sustain one line per cycle.
REQ-023 On miss at cycle N, the FSM SHALL latch the address and enter MISS at N+1 with mem_req = 1 and mem_addr = latched line address.
REQ-024 MISS SHALL hold mem_req/mem_addr stable until mem_ack, then enter REFILL with mem_req = 0.
REQ-025 REFILL SHALL count N_BEATS mem_rvalid beats, placing beat k at bits [k*W_MEM +: W_MEM]; after the last beat it SHALL enter FILL.
REQ-026 FILL SHALL write data, tag and valid=1 to the latched index, drive ifq_dout_valid = 1 with the refilled line the following cycle, and return to IDLE.
REQ-027 ifq_abort with ifq_ren in IDLE SHALL suppress the lookup (no dout_valid, no miss).
REQ-028 ifq_abort in MISS before mem_ack SHALL return to IDLE with no request issued; abort on the mem_ack cycle SHALL be treated as after acceptance.
REQ-029 ifq_abort in REFILL or FILL SHALL be latched: refill completes and the line is written, but no ifq_dout_valid pulse.
REQ-030 ifq_flush in IDLE SHALL clear all valid bits in one cycle, taking priority over a same-cycle ifq_ren (treated as miss after flush).
REQ-031 ifq_flush when not IDLE SHALL be held pending and applied on the cycle the FSM returns to IDLE, after the FILL write.
REQ-032 ifq_dout SHALL hold its last value when ifq_dout_valid = 0.
REQ-033 mem_rvalid outside REFILL SHALL be ignored.

Reset
REQ-034 Reset SHALL force state IDLE, all valid bits 0, beat counter 0, pending abort/flush 0, and ifq_dout, ifq_dout_valid, ifq_busy, mem_req, mem_addr to 0.
REQ-035 Data and tag arrays SHALL NOT require reset.
REQ-036 Reset asserted mid-refill SHALL abandon the refill immediately with no array write.

Structure
REQ-037 Package icache_pkg SHALL hold the FSM state encoding and the derived widths (offset, tag, N_BEATS, beat-counter width).
REQ-038 One sub-module icache_array SHALL hold valid/tag/data storage with a combinational read port and one write port plus a flush-all input.

Verification
REQ-039 Cold miss: after reset, ren at 0x0000_0040 -> mem_req with mem_addr 0x40; ack; beats 0x11,0x22,0x33,0x44 -> dout 0x00000044_00000033_00000022_00000011, valid pulse once.
REQ-040 Hit stream: after REQ-039, ren at 0x40,0x44,0x48 on three consecutive cycles -> three consecutive valid pulses, same line, no mem_req.
REQ-041 Conflict: ren 0x0000_0440 (same index 4, tag 1) -> miss and refill; then ren 0x40 -> miss again.
REQ-042 Abort: abort in MISS before ack -> IDLE, mem_req drops, no pulse; abort mid-REFILL -> line written, no pulse, later ren hits.
REQ-043 Flush: flush in IDLE -> next ren 0x40 misses; flush during REFILL -> applied after FILL, next ren misses.
REQ-044 Reset mid-REFILL after 2 beats -> all outputs 0 immediately, next ren 0x40 misses.
